// File: rtl/csa_pkg.sv
// Shared state type and sizing helpers for the carry-save accumulator/resolver.
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } csa_state_e;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 16;

    // A single-chunk resolve still needs a 1-bit counter to keep the port legal.
    function automatic int chunk_cnt_w(input int width, input int chunk);
        return (width / chunk > 1) ? $clog2(width / chunk) : 1;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Combinational 3:2 carry-save compressor; carry is returned unshifted plus its MSB.
module csa_3to2
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             carry_msb
);

    assign sum       = x ^ y ^ z;
    assign carry     = (x & y) | (x & z) | (y & z);
    assign carry_msb = carry[WIDTH-1];

endmodule

// File: rtl/csa_accum_resolve.sv
// Carry-save multi-operand accumulator with chunked carry-propagate resolve.
// Optional overflow tracking and the out_ovf port are enabled by CSA_OVF_DETECT_EN.
module csa_accum_resolve
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum
`ifdef CSA_OVF_DETECT_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = chunk_cnt_w(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_chunk_check
        $error("csa_accum_resolve: WIDTH must be a multiple of CHUNK");
    end

    csa_state_e       state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    logic [WIDTH-1:0] csa_sum;
    logic [WIDTH-1:0] csa_carry;
    logic             csa_carry_msb;
    logic [CHUNK-1:0] s_chunk, c_chunk, add_chunk;
    logic             cy_n;

    csa_3to2 #(.WIDTH(WIDTH)) u_csa (
        .x         (s_q),
        .y         (c_q),
        .z         (in_data),
        .sum       (csa_sum),
        .carry     (csa_carry),
        .carry_msb (csa_carry_msb)
    );

    // The top carry bit is shifted out of the word; only overflow tracking may observe it.
    logic unused_carry_top;
    assign unused_carry_top = csa_carry[WIDTH-1];

`ifdef CSA_OVF_DETECT_EN
    logic ovf_q, ovf_d;
    assign out_ovf = ovf_q;
`else
    logic unused_carry_msb;
    assign unused_carry_msb = csa_carry_msb;
`endif

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        sum_d   = sum_q;
`ifdef CSA_OVF_DETECT_EN
        ovf_d   = ovf_q;
`endif
        s_chunk = '0;
        c_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) begin
                s_chunk = s_q[k*CHUNK +: CHUNK];
                c_chunk = c_q[k*CHUNK +: CHUNK];
            end
        end
        {cy_n, add_chunk} = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cy_q};

        unique case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    s_d = csa_sum;
                    c_d = {csa_carry[WIDTH-2:0], 1'b0};
`ifdef CSA_OVF_DETECT_EN
                    ovf_d = ovf_q | csa_carry_msb;
`endif
                    if (in_last) begin
                        state_d = RESOLVE;
                        cnt_d   = '0;
                        cy_d    = 1'b0;
                    end
                end
            end
            RESOLVE: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (cnt_q == CW'(k)) begin
                        sum_d[k*CHUNK +: CHUNK] = add_chunk;
                    end
                end
                cy_d  = cy_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
`ifdef CSA_OVF_DETECT_EN
                    ovf_d = ovf_q | cy_n;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    s_d     = '0;
                    c_d     = '0;
`ifdef CSA_OVF_DETECT_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
`ifdef CSA_OVF_DETECT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            sum_q   <= sum_d;
`ifdef CSA_OVF_DETECT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule
